spi_slave_core: RTL and testbench
=================================

# spi_slave_core

Mode-configurable SPI slave, clocked entirely from the fabric clock `clk`; the SPI pins are oversampled and synchronized. One 8-bit transfer per `select` assertion, MSB first. Sits between external SPI pins and internal logic: it offers the transmit byte via a `start`/`din` load, and returns the received byte on `dout` with a `done` strobe. The RTL module is named `spi_slave_core`; it implements the `spi_slave` function.

## Interface
- No parameters; word width fixed at 8 bits.
- `clk` in 1: system clock. One clock; all state clocked on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpol` in 1: idle level of `mclk`. Quasi-static; captured when a transfer starts.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge. Captured at start.
- `select` in 1: chip select, active high, asynchronous.
- `mclk` in 1: SPI clock from master, asynchronous.
- `mosi` in 1: master-out data, asynchronous.
- `miso` out 1: slave-out data. Equals tx shift MSB while busy; 0 otherwise.
- `din` in 8: byte to transmit. Sampled only in the cycle `start`=1.
- `dout` out 8: last received byte. Updated when `done` pulses; held otherwise.
- `start` out 1: one-cycle pulse at transfer begin.
- `done` out 1: one-cycle pulse at transfer completion.
- `busy` out 1: high from the `start` cycle through the cycle before `done`.

## Operation
- Synchronize `select`, `mclk` and `mosi` with 2-FF synchronizers. Detect `mclk` edges by comparing the synchronized value with its one-cycle delayed copy.
  - Leading edge: idle→active (away from `cpol`).
  - Trailing edge: active→idle.
- States: IDLE, LOAD, SHIFT.
- IDLE: `miso`=0. On synchronized `select` rising edge → LOAD, `start`=1.
- LOAD (one cycle, `start`=1):
  - tx_shift ← `din`.
  - Latch `cpol` and `cpha`.
  - bit counter ← 0; `busy`=1.
  - → SHIFT.
- SHIFT with `cpha`=0:
  - Leading edge: rx ← {rx[6:0], mosi_sync}.
  - Trailing edge: tx_shift ← tx_shift<<1; count++.
- SHIFT with `cpha`=1:
  - Leading edge: shift tx, except on the first leading edge (bit 7 is already presented).
  - Trailing edge: sample into rx; count++.
- Completion: on the 8th trailing edge, in both modes:
  - `dout` ← final rx value, including the bit sampled on that edge for `cpha`=1.
  - `done`=1 for one cycle; `busy`=0 that same cycle.
  - → IDLE.
- `miso` = tx_shift[7] in LOAD and SHIFT, so `din[7]` is valid before the first edge.
- `select` falling while in SHIFT aborts: → IDLE, no `done`, `dout` unchanged, `busy`=0.
- `mclk` edges in IDLE are ignored. A new transfer requires `select` to be deasserted and reasserted.
- `select` still high after `done`: stay IDLE and ignore clocks until `select` drops.

## Timing
- Reset values: `miso`, `start`, `done`, `busy` = 0; `dout` = 8'h00; state IDLE.
- `start` rises 3 clk cycles after `select` rises: 2 sync stages plus edge detect. `start` is exactly 1 cycle.
- `busy` rises together with `start`. The master must not toggle `mclk` before `start`.
- Each `mclk` edge acts 3 clk cycles after the pin transition.
- `mclk` high and low phases must each be ≥4 clk cycles.
- `done` follows the 8th trailing edge of `mclk` by 3 cycles.
- `dout` is valid in the `done` cycle and stays stable until the next `done`.
- `cpol`/`cpha` changes mid-transfer are ignored.

## Structure
- A shared package holds the state enum (IDLE/LOAD/SHIFT) and the word width constant (8).
- One natural sub-module: `sync2`, a 2-FF synchronizer with async active-low reset. Instantiate it three times.

## Test plan
- Mode 0 (`cpol`=0, `cpha`=0): master sends a1, slave `din`=b2 → at `done`: `dout`=a1, master has shifted in b2, `busy`=0. Repeat with 51/62.
- Mode 2 (`cpol`=1, `cpha`=0): same byte pairs → `dout`=a1/51; master receives b2/62.
- Mode 1 (`cpol`=0, `cpha`=1): same byte pairs → same results.
- Mode 3 (`cpol`=1, `cpha`=1): same byte pairs → same results.
- Abort: deassert `select` after 4 clocks → no `done`; `dout` keeps its previous value; `busy`=0. The next full transfer succeeds.
- Reset: pulse `rst_n` low mid-transfer → all outputs 0 immediately. The next transfer after `select` re-rises is correct.

Source files
------------

// File: rtl/spi_slave_core_pkg.sv
// Shared types and constants for the SPI slave core.
package spi_slave_core_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_core_if.sv
// Pin-side and fabric-side signals of the SPI slave, bundled for port hookup.
interface spi_slave_core_if;
    import spi_slave_core_pkg::*;

    logic             cpol;
    logic             cpha;
    logic             select;
    logic             mclk;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             start;
    logic             done;
    logic             busy;

    modport slave (
        input  cpol, cpha, select, mclk, mosi, din,
        output miso, dout, start, done, busy
    );

    modport master (
        output cpol, cpha, select, mclk, mosi, din,
        input  miso, dout, start, done, busy
    );

endinterface

// File: rtl/spi_slave_core_sync2.sv
// Two-flop synchronizer for an asynchronous pin into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back capture stages to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_slave_core.sv
// Oversampled SPI slave: one MSB-first byte per select assertion, all four modes.
module spi_slave_core
    import spi_slave_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_core_if.slave  bus
);

    logic sel_s, mclk_s, mosi_s;

    sync2 u_sync_sel  (.clk(clk), .rst_n(rst_n), .d(bus.select), .q(sel_s));
    sync2 u_sync_mclk (.clk(clk), .rst_n(rst_n), .d(bus.mclk),   .q(mclk_s));
    sync2 u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(bus.mosi),   .q(mosi_s));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             sel_dly_q, mclk_dly_q;

    logic             sel_rise, mclk_chg, lead, trail, last_bit;
    logic [WIDTH-1:0] rx_next;

    assign sel_rise = sel_s & ~sel_dly_q;
    assign mclk_chg = mclk_s ^ mclk_dly_q;
    // Leading edge moves away from the idle level latched at transfer start.
    assign lead     = mclk_chg & (mclk_s != cpol_q);
    assign trail    = mclk_chg & (mclk_s == cpol_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign rx_next  = {rx_q[WIDTH-2:0], mosi_s};

    // Delayed copies of the synchronized select and mclk for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_dly_q  <= 1'b0;
            mclk_dly_q <= 1'b0;
        end else begin
            sel_dly_q  <= sel_s;
            mclk_dly_q <= mclk_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    // Next-state and shift logic; done is registered so it lands with the return to IDLE.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        first_d = first_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_d    = bus.din;
                cpol_d  = bus.cpol;
                cpha_d  = bus.cpha;
                cnt_d   = '0;
                first_d = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!sel_s) begin
                    state_d = ST_IDLE;
                end else if (!cpha_q) begin
                    if (lead) begin
                        rx_d = rx_next;
                    end else if (trail) begin
                        tx_d  = tx_q << 1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            dout_d  = rx_q;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    if (lead) begin
                        // Bit 7 is already on miso from LOAD, so the first leading edge holds.
                        if (!first_q) tx_d = tx_q << 1;
                        first_d = 1'b0;
                    end else if (trail) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            dout_d  = rx_next;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.miso  = (state_q != ST_IDLE) & tx_q[WIDTH-1];
    assign bus.start = (state_q == ST_LOAD);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.dout  = dout_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: bit-banged SPI master plus scoreboard.
module tb_spi_slave_core;

    localparam int HALF = 8;

    logic clk;
    logic rst_n;
    spi_slave_core_if bus();

    spi_slave_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    logic [7:0] m_rx;
    logic [7:0] last_dout;
    logic [7:0] exp_dout_q[$];
    logic [7:0] exp_mrx_q[$];

    // Count every done pulse so aborts can be checked for silence.
    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic begin_xfer(input logic pol, input logic pha, input logic [7:0] sdin);
        int lat;
        bus.cpol = pol;
        bus.cpha = pha;
        bus.mclk = pol;
        bus.din  = sdin;
        repeat (6) @(negedge clk);
        bus.select = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.start !== 1'b1 && lat < 12);
        check_eq("start_lat", lat, 3);
        check_eq("busy_at_start", bus.busy, 1'b1);
        @(negedge clk);
        check_eq("start_pulse", bus.start, 1'b0);
    endtask

    task automatic shift_bits(input logic pol, input logic pha, input logic [7:0] mtx, input int n);
        for (int i = 0; i < n; i++) begin
            if (!pha) begin
                bus.mosi = mtx[7-i];
                repeat (HALF) @(negedge clk);
                bus.mclk = ~pol;
                m_rx = {m_rx[6:0], bus.miso};
                repeat (HALF) @(negedge clk);
                bus.mclk = pol;
            end else begin
                repeat (HALF) @(negedge clk);
                bus.mclk = ~pol;
                bus.mosi = mtx[7-i];
                repeat (HALF) @(negedge clk);
                bus.mclk = pol;
                m_rx = {m_rx[6:0], bus.miso};
            end
        end
    endtask

    task automatic finish_xfer();
        int lat;
        logic [7:0] e_dout, e_mrx;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < 12);
        check_eq("done_lat", lat, 3);
        e_dout = exp_dout_q.pop_front();
        e_mrx  = exp_mrx_q.pop_front();
        check_eq("dout", bus.dout, e_dout);
        check_eq("master_rx", m_rx, e_mrx);
        check_eq("busy_at_done", bus.busy, 1'b0);
        last_dout = e_dout;
        @(negedge clk);
        check_eq("done_pulse", bus.done, 1'b0);
        check_eq("dout_hold", bus.dout, e_dout);
        bus.select = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic full_xfer(input logic pol, input logic pha, input logic [7:0] mtx, input logic [7:0] sdin);
        exp_dout_q.push_back(mtx);
        exp_mrx_q.push_back(sdin);
        m_rx = 8'h00;
        begin_xfer(pol, pha, sdin);
        shift_bits(pol, pha, mtx, 8);
        finish_xfer();
    endtask

    initial begin
        int d0;
        rst_n      = 1'b0;
        bus.cpol   = 1'b0;
        bus.cpha   = 1'b0;
        bus.select = 1'b0;
        bus.mclk   = 1'b0;
        bus.mosi   = 1'b0;
        bus.din    = 8'h00;
        last_dout  = 8'h00;
        m_rx       = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_miso",  bus.miso,  1'b0);
        check_eq("rst_start", bus.start, 1'b0);
        check_eq("rst_done",  bus.done,  1'b0);
        check_eq("rst_busy",  bus.busy,  1'b0);
        check_eq("rst_dout",  bus.dout,  8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int m = 0; m < 4; m++) begin
            logic pol, pha;
            pol = (m == 2 || m == 3);
            pha = (m == 1 || m == 3);
            full_xfer(pol, pha, 8'hA1, 8'hB2);
            full_xfer(pol, pha, 8'h51, 8'h62);
        end

        // Abort: select drops early, dout must keep the last completed byte.
        d0 = done_cnt;
        begin_xfer(1'b0, 1'b0, 8'h3C);
        repeat (3) @(negedge clk);
        bus.select = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_dout", bus.dout, last_dout);
        check_eq("abort_busy", bus.busy, 1'b0);
        full_xfer(1'b0, 1'b0, 8'h96, 8'h69);

        // Reset in the middle of a transfer.
        m_rx = 8'h00;
        begin_xfer(1'b1, 1'b1, 8'hE7);
        shift_bits(1'b1, 1'b1, 8'h18, 3);
        rst_n      = 1'b0;
        bus.select = 1'b0;
        #1;
        check_eq("midrst_miso",  bus.miso,  1'b0);
        check_eq("midrst_start", bus.start, 1'b0);
        check_eq("midrst_done",  bus.done,  1'b0);
        check_eq("midrst_busy",  bus.busy,  1'b0);
        check_eq("midrst_dout",  bus.dout,  8'h00);
        last_dout = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        full_xfer(1'b1, 1'b1, 8'hC3, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
